// File: rtl/mbist_march_gen_if.sv
// mbist_march_gen_if: bundles the BIST handshake, the SRAM port and the
// fail-status signals of the March C- sequencer.
// The sequencer itself connects to the master modport.
// The BIST controller and the SRAM port mux connect to the slave modport.
interface mbist_march_gen_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int ERR_W  = 8
);
    logic              start;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              re;
    logic              busy;
    logic              done;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [2:0]        fail_elem;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        input  start, rdata,
        output addr, wdata, we, re, busy, done,
        output fail, fail_addr, fail_elem, err_cnt
    );

    modport slave (
        output start, rdata,
        input  addr, wdata, we, re, busy, done,
        input  fail, fail_addr, fail_elem, err_cnt
    );
endinterface

// File: rtl/mbist_march_gen.sv
// mbist_march_gen: March C- MBIST sequencer for a single-port SRAM.
// Sequence:
//   {up(w D); up(r D,w ~D); up(r ~D,w D); dn(r D,w ~D); dn(r ~D,w D); up(r D)}
// The run issues one op per cycle, 10N ops in total.
// Each read's expected value is compared RD_LAT cycles later.
// Optional macro MBIST_CHKBD_EN switches the background D from all-zeros to an
// address-parity checkerboard.
module mbist_march_gen #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 8
) (
    input logic clk,
    input logic rst,
    mbist_march_gen_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [1:0]        state;
    logic [2:0]        elem;       // March element index 0..5
    logic [ADDR_W-1:0] acnt;       // current address within the element
    logic              phase;      // 0: read op, 1: write op of a two-op element
    logic [2:0]        drain_cnt;

    logic              single_op;
    logic              rd_inv;
    logic              wr_inv;
    logic              down;
    logic              is_read;
    logic              is_write;
    logic              last_addr;
    logic              restart;
    logic [DATA_W-1:0] bg;
    logic [DATA_W-1:0] op_data;

    logic              pv    [RD_LAT];
    logic [DATA_W-1:0] pexp  [RD_LAT];
    logic [ADDR_W-1:0] paddr [RD_LAT];
    logic [2:0]        pelem [RD_LAT];
    logic              mismatch;

    logic              fail_r;
    logic [ADDR_W-1:0] fail_addr_r;
    logic [2:0]        fail_elem_r;
    logic [ERR_W-1:0]  err_r;

`ifdef MBIST_CHKBD_EN
    assign bg = {DATA_W{acnt[0] ^ acnt[ADDR_W-1]}};
`else
    assign bg = '0;
`endif

    // Element decode: M0 and M5 are single-op elements, and M3 and M4 run downwards.
    assign single_op = (elem == 3'd0) || (elem == 3'd5);
    assign rd_inv    = (elem == 3'd2) || (elem == 3'd4);
    assign wr_inv    = (elem == 3'd1) || (elem == 3'd3);
    assign down      = (elem == 3'd3) || (elem == 3'd4);
    assign is_read   = (state == RUN) && (elem != 3'd0) && !phase;
    assign is_write  = (state == RUN) && ((elem == 3'd0) || phase);
    assign last_addr = down ? (acnt == '0) : (acnt == ADDR_MAX);
    assign op_data   = is_read ? (rd_inv ? ~bg : bg) : (wr_inv ? ~bg : bg);
    assign restart   = ((state == IDLE) || (state == DONE)) && bus.start;

    // Sequencer FSM: steps through the ops, addresses and elements, then waits for the compare pipeline to drain.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            elem      <= '0;
            acnt      <= '0;
            phase     <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state <= RUN;
                        elem  <= '0;
                        acnt  <= '0;
                        phase <= 1'b0;
                    end
                end
                RUN: begin
                    if (!single_op && !phase) begin
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (!last_addr) begin
                            acnt <= down ? acnt - 1'b1 : acnt + 1'b1;
                        end else if (elem == 3'd5) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            elem <= elem + 3'd1;
                            // Elements M3 and M4 start from the top address.
                            acnt <= ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_MAX : '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 3'(RD_LAT - 1)) state <= DONE;
                    else                             drain_cnt <= drain_cnt + 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Compare pipeline valid bits: one slot per read, flushed on reset.
    // NOTE: only the valid bits are reset; the payload below is qualified by them, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= is_read;
            for (int i = 1; i < RD_LAT; i++) pv[i] <= pv[i-1];
        end
    end

    // Compare pipeline payload: expected data, address and element index for each read.
    always_ff @(posedge clk) begin
        pexp[0]  <= op_data;
        paddr[0] <= acnt;
        pelem[0] <= elem;
        for (int i = 1; i < RD_LAT; i++) begin
            pexp[i]  <= pexp[i-1];
            paddr[i] <= paddr[i-1];
            pelem[i] <= pelem[i-1];
        end
    end

    assign mismatch = pv[RD_LAT-1] && (bus.rdata != pexp[RD_LAT-1]);

    // Fail status: sticky flag, first-fail capture and a saturating error count; all cleared on restart.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            fail_r      <= 1'b0;
            fail_addr_r <= '0;
            fail_elem_r <= '0;
            err_r       <= '0;
        end else if (mismatch) begin
            fail_r <= 1'b1;
            if (!fail_r) begin
                fail_addr_r <= paddr[RD_LAT-1];
                fail_elem_r <= pelem[RD_LAT-1];
            end
            if (err_r != '1) err_r <= err_r + 1'b1;
        end
    end

    assign bus.we        = is_write;
    assign bus.re        = is_read;
    assign bus.addr      = (state == RUN) ? acnt : '0;
    assign bus.wdata     = is_write ? op_data : '0;
    assign bus.busy      = (state == RUN) || (state == DRAIN);
    assign bus.done      = (state == DONE);
    assign bus.fail      = fail_r;
    assign bus.fail_addr = fail_addr_r;
    assign bus.fail_elem = fail_elem_r;
    assign bus.err_cnt   = err_r;
endmodule

// File: tb/tb_mbist_march_gen.sv
// tb_mbist_march_gen: scoreboard bench for mbist_march_gen.
// Two instances are exercised, one with RD_LAT=1 and one with RD_LAT=3, each
// driving a behavioural SRAM with an optional stuck-at-1 on bit 2 of address 5.
// Build with +define+MBIST_CHKBD_EN to check the checkerboard background.
module tb_mbist_march_gen;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int EW = 8;
    localparam int N  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mbist_march_gen_if #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(EW)) if1 ();
    mbist_march_gen_if #(.ADDR_W(AW), .DATA_W(DW), .ERR_W(EW)) if3 ();

    mbist_march_gen #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .ERR_W(EW)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );
    mbist_march_gen #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .ERR_W(EW)) dut3 (
        .clk(clk), .rst(rst), .bus(if3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit             stuck_en = 1'b0;
    bit             sel = 1'b0;
    logic [DW-1:0]  mem1 [N];
    logic [DW-1:0]  mem3 [N];
    logic [DW-1:0]  rd3  [3];
    logic [9:0]     exp_q [$];

    logic [9:0]     obs_op;
    logic           obs_busy, obs_done, obs_fail;
    logic [AW-1:0]  obs_faddr;
    logic [2:0]     obs_felem;
    logic [EW-1:0]  obs_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] v, input logic [AW-1:0] a);
        return (stuck_en && a == AW'(5)) ? (v | 4'b0100) : v;
    endfunction

    function automatic logic [DW-1:0] bg_of(input int a);
`ifdef MBIST_CHKBD_EN
        return (((a & 1) ^ ((a >> (AW - 1)) & 1)) != 0) ? 4'hF : 4'h0;
`else
        return (a < 0) ? 4'hF : 4'h0;
`endif
    endfunction

    // Behavioural SRAMs: latency 1 for dut1, latency 3 for dut3.
    always @(posedge clk) begin
        if (if1.we) mem1[if1.addr] <= if1.wdata;
        if (if1.re) if1.rdata <= rd_fault(mem1[if1.addr], if1.addr);
        if (if3.we) mem3[if3.addr] <= if3.wdata;
        rd3[0] <= rd_fault(mem3[if3.addr], if3.addr);
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign if3.rdata = rd3[2];

    // Observation mux selects the instance under test.
    always_comb begin
        if (sel) begin
            obs_op    = {if3.we, if3.re, if3.addr, if3.wdata};
            obs_busy  = if3.busy;
            obs_done  = if3.done;
            obs_fail  = if3.fail;
            obs_faddr = if3.fail_addr;
            obs_felem = if3.fail_elem;
            obs_err   = if3.err_cnt;
        end else begin
            obs_op    = {if1.we, if1.re, if1.addr, if1.wdata};
            obs_busy  = if1.busy;
            obs_done  = if1.done;
            obs_fail  = if1.fail;
            obs_faddr = if1.fail_addr;
            obs_felem = if1.fail_elem;
            obs_err   = if1.err_cnt;
        end
    end

    task automatic set_start(input bit use3, input logic v);
        if (use3) if3.start = v;
        else      if1.start = v;
    endtask

    task automatic run_march(input bit use3, input bit stuck, input bit poke_start, input int abort_at);
        int            lat, ecnt, fa, fe, cyc;
        bit            seen;
        logic [9:0]    e_op;
        logic [DW-1:0] d, rexp, rgot;
        lat = use3 ? 3 : 1;
        sel = use3;
        stuck_en = stuck;
        exp_q.delete();
        ecnt = 0; fa = 0; fe = 0; seen = 1'b0;
        // Reference March C- model: expected op stream and expected fail status.
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < N; k++) begin
                int a;
                a = (e == 3 || e == 4) ? N - 1 - k : k;
                d = bg_of(a);
                if (e != 0) begin
                    rexp = (e == 2 || e == 4) ? ~d : d;
                    exp_q.push_back({2'b01, AW'(a), 4'h0});
                    rgot = (stuck && a == 5) ? (rexp | 4'b0100) : rexp;
                    if (rgot != rexp) begin
                        if (!seen) begin fa = a; fe = e; seen = 1'b1; end
                        ecnt++;
                    end
                end
                if (e != 5) exp_q.push_back({2'b10, AW'(a), (e == 1 || e == 3) ? ~d : d});
            end
        end

        @(negedge clk);
        set_start(use3, 1'b1);
        @(negedge clk);
        set_start(use3, 1'b0);
        cyc = 1;
        forever begin
            if (obs_op[9] | obs_op[8]) begin
                if (exp_q.size() == 0) begin
                    check("extra_op", 1, 0);
                end else begin
                    e_op = exp_q.pop_front();
                    check($sformatf("op_c%0d", cyc), obs_op, e_op);
                end
            end
            if (obs_done) break;
            if (cyc > 10 * N + lat + 10) begin
                check("timeout", 0, 1);
                break;
            end
            if (abort_at != 0 && cyc == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_op", obs_op, 0);
                check("rst_busy", obs_busy, 0);
                check("rst_done", obs_done, 0);
                check("rst_fail", obs_fail, 0);
                check("rst_err", obs_err, 0);
                rst = 1'b0;
                return;
            end
            if (poke_start) set_start(use3, (cyc == 40) ? 1'b1 : 1'b0);
            @(negedge clk);
            cyc++;
        end
        set_start(use3, 1'b0);

        check("done_cycle", cyc, 10 * N + lat + 1);
        check("busy_at_done", obs_busy, 0);
        check("ops_left", exp_q.size(), 0);
        check("fail", obs_fail, (ecnt != 0) ? 1 : 0);
        check("err_cnt", obs_err, ecnt);
        if (ecnt != 0) begin
            check("fail_addr", obs_faddr, fa);
            check("fail_elem", obs_felem, fe);
        end
        @(negedge clk);
        check("done_hold", obs_done, 1);
    endtask

    initial begin
        if1.start = 1'b0;
        if3.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_op", obs_op, 0);
        check("reset_busy", obs_busy, 0);
        check("reset_done", obs_done, 0);
        check("reset_err", obs_err, 0);
        check("reset_busy3", if3.busy, 0);
        rst = 1'b0;

        run_march(1'b0, 1'b0, 1'b0, 0);   // ideal SRAM
        run_march(1'b0, 1'b1, 1'b1, 0);   // stuck-at fault, start poked during RUN
        run_march(1'b0, 1'b0, 1'b0, 0);   // restart from DONE clears status
        run_march(1'b0, 1'b1, 1'b0, 53);  // reset mid-M2
        run_march(1'b0, 1'b0, 1'b0, 0);   // clean rerun after reset
        run_march(1'b1, 1'b1, 1'b0, 0);   // RD_LAT=3 with fault

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
